// File: rtl/decode_scoreboard_rf.sv
// Decode/register-read stage: multi-port register file with write-back bypass and a RAW pending-write scoreboard.
// Latency: one cycle from issue (inst_valid & id_ready) to the ID/IX register.
// Backpressure: ID/IX holds while valid & ~ready_ixid; fetch is stalled by hazards, full counters, flush or a blocked ID/IX.
module decode_scoreboard_rf #(
    parameter int DATA_W   = 16,
    parameter int INST_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int WB_PORTS = 2,
    parameter int PEND_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_valid_ifid_p1,
    output logic                         id_ready_idif_p1,
    input  logic [INST_W-1:0]            inst_ifid_p1,
    input  logic [15:0]                  pc_ifid_p1,
    input  logic [IDX_W-1:0]             rs_index_p1,
    input  logic [IDX_W-1:0]             rt_index_p1,
    input  logic                         rs_used_p1,
    input  logic                         rt_used_p1,
    input  logic [IDX_W-1:0]             dest_index_p1,
    input  logic                         dest_wr_p1,
    input  logic [WB_PORTS-1:0]          wb_valid_p1,
    input  logic [WB_PORTS*IDX_W-1:0]    wb_index_p1,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data_p1,
    input  logic                         flush_p1,
    output logic                         valid_idix_p1,
    input  logic                         ready_ixid_p1,
    output logic [INST_W-1:0]            inst_idix_p1,
    output logic [15:0]                  pc_idix_p1,
    output logic [DATA_W-1:0]            rs_idix_p1,
    output logic [DATA_W-1:0]            rt_idix_p1,
    output logic [IDX_W-1:0]             dest_idix_p1,
    output logic                         dest_wr_idix_p1
);

    // Hit counter must hold WB_PORTS; the sum must hold a saturated count plus one issue.
    localparam int HIT_W = $clog2(WB_PORTS + 1);
    localparam int SUM_W = ((PEND_W > HIT_W) ? PEND_W : HIT_W) + 1;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]   r_rf  [NUM_REGS];
    logic [PEND_W-1:0]   r_cnt [NUM_REGS];

    logic                r_valid;
    logic [INST_W-1:0]   r_inst;
    logic [15:0]         r_pc;
    logic [DATA_W-1:0]   r_rs;
    logic [DATA_W-1:0]   r_rt;
    logic [IDX_W-1:0]    r_dest;
    logic                r_dest_wr;

    logic [NUM_REGS-1:0] w_wb_hit;
    logic [DATA_W-1:0]   w_wb_dat  [NUM_REGS];
    logic [HIT_W-1:0]    w_wb_num  [NUM_REGS];
    logic [PEND_W-1:0]   w_cnt_nxt [NUM_REGS];
    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_dec;

    logic [DATA_W-1:0]   w_rs_val;
    logic [DATA_W-1:0]   w_rt_val;
    logic [PEND_W-1:0]   w_rs_cnt;
    logic [PEND_W-1:0]   w_rt_cnt;
    logic                w_rs_haz;
    logic                w_rt_haz;
    logic                w_dest_full;
    logic                w_ixid_free;
    logic                w_issue;

    // Per-register write-back decode; scanning ports upward lets the highest port win.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wb_hit[r] = 1'b0;
            w_wb_dat[r] = '0;
            w_wb_num[r] = '0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid_p1[p] && (wb_index_p1[p*IDX_W +: IDX_W] == IDX_W'(r))) begin
                    w_wb_hit[r] = 1'b1;
                    w_wb_dat[r] = wb_data_p1[p*DATA_W +: DATA_W];
                    w_wb_num[r] = w_wb_num[r] + HIT_W'(1);
                end
            end
        end
    end

    // Operand read with same-cycle write-back bypass.
    assign w_rs_val = w_wb_hit[rs_index_p1] ? w_wb_dat[rs_index_p1] : r_rf[rs_index_p1];
    assign w_rt_val = w_wb_hit[rt_index_p1] ? w_wb_dat[rt_index_p1] : r_rf[rt_index_p1];

    // A single outstanding write that lands this cycle is covered by the bypass.
    assign w_rs_cnt = r_cnt[rs_index_p1];
    assign w_rt_cnt = r_cnt[rt_index_p1];
    assign w_rs_haz = rs_used_p1 &
                      ((w_rs_cnt > PEND_W'(1)) | ((w_rs_cnt == PEND_W'(1)) & ~w_wb_hit[rs_index_p1]));
    assign w_rt_haz = rt_used_p1 &
                      ((w_rt_cnt > PEND_W'(1)) | ((w_rt_cnt == PEND_W'(1)) & ~w_wb_hit[rt_index_p1]));
    assign w_dest_full = dest_wr_p1 & (r_cnt[dest_index_p1] == CNT_MAX) & ~w_wb_hit[dest_index_p1];

    assign w_ixid_free      = ~r_valid | ready_ixid_p1;
    assign id_ready_idif_p1 = rst & ~flush_p1 & w_ixid_free & ~w_rs_haz & ~w_rt_haz & ~w_dest_full;
    assign w_issue          = inst_valid_ifid_p1 & id_ready_idif_p1;

    // Scoreboard next state: add the issuing write, subtract landing writes, floor at zero; flush clears.
    always_comb begin
        w_sum = '0;
        w_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_sum = SUM_W'(r_cnt[r]) +
                    SUM_W'(w_issue && dest_wr_p1 && (dest_index_p1 == IDX_W'(r)));
            w_dec = SUM_W'(w_wb_num[r]);
            w_cnt_nxt[r] = (w_sum > w_dec) ? PEND_W'(w_sum - w_dec) : '0;
            if (flush_p1) begin
                w_cnt_nxt[r] = '0;
            end
        end
    end

    // Register file update from the merged write-back (applies during flush too).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_rf[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_wb_hit[r]) begin
                    r_rf[r] <= w_wb_dat[r];
                end
            end
        end
    end

    // Scoreboard counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
        end
    end

    // ID/IX pipeline register: load on issue, invalidate on flush or drain, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_inst    <= '0;
            r_pc      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_dest_wr <= 1'b0;
        end else if (w_issue) begin
            r_valid   <= 1'b1;
            r_inst    <= inst_ifid_p1;
            r_pc      <= pc_ifid_p1;
            r_rs      <= w_rs_val;
            r_rt      <= w_rt_val;
            r_dest    <= dest_index_p1;
            r_dest_wr <= dest_wr_p1;
        end else if (flush_p1 || ready_ixid_p1) begin
            r_valid   <= 1'b0;
        end
    end

    assign valid_idix_p1   = r_valid;
    assign inst_idix_p1    = r_inst;
    assign pc_idix_p1      = r_pc;
    assign rs_idix_p1      = r_rs;
    assign rt_idix_p1      = r_rt;
    assign dest_idix_p1    = r_dest;
    assign dest_wr_idix_p1 = r_dest_wr;

endmodule

// File: tb/tb_decode_scoreboard_rf.sv
// Directed bench for decode_scoreboard_rf: read, bypass, RAW interlock, saturation, backpressure, flush, reset.
// Inputs change 1 time unit after the rising edge; registered outputs are sampled there too.
// Combinational ready is sampled 2 time units after the edge, once inputs have settled.
module tb_decode_scoreboard_rf;

    localparam int DATA_W   = 16;
    localparam int INST_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;
    localparam int WB_PORTS = 2;
    localparam int PEND_W   = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       inst_valid;
    logic                       id_ready;
    logic [INST_W-1:0]          inst;
    logic [15:0]                pc;
    logic [IDX_W-1:0]           rs_idx;
    logic [IDX_W-1:0]           rt_idx;
    logic                       rs_used;
    logic                       rt_used;
    logic [IDX_W-1:0]           dest_idx;
    logic                       dest_wr;
    logic [WB_PORTS-1:0]        wb_valid;
    logic [WB_PORTS*IDX_W-1:0]  wb_index;
    logic [WB_PORTS*DATA_W-1:0] wb_data;
    logic                       flush;
    logic                       valid_idix;
    logic                       ready_ixid;
    logic [INST_W-1:0]          inst_idix;
    logic [15:0]                pc_idix;
    logic [DATA_W-1:0]          rs_idix;
    logic [DATA_W-1:0]          rt_idix;
    logic [IDX_W-1:0]           dest_idix;
    logic                       dest_wr_idix;

    int n_checks = 0;
    int n_errors = 0;

    decode_scoreboard_rf #(
        .DATA_W(DATA_W), .INST_W(INST_W), .NUM_REGS(NUM_REGS),
        .IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .PEND_W(PEND_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .inst_valid_ifid_p1 (inst_valid),
        .id_ready_idif_p1   (id_ready),
        .inst_ifid_p1       (inst),
        .pc_ifid_p1         (pc),
        .rs_index_p1        (rs_idx),
        .rt_index_p1        (rt_idx),
        .rs_used_p1         (rs_used),
        .rt_used_p1         (rt_used),
        .dest_index_p1      (dest_idx),
        .dest_wr_p1         (dest_wr),
        .wb_valid_p1        (wb_valid),
        .wb_index_p1        (wb_index),
        .wb_data_p1         (wb_data),
        .flush_p1           (flush),
        .valid_idix_p1      (valid_idix),
        .ready_ixid_p1      (ready_ixid),
        .inst_idix_p1       (inst_idix),
        .pc_idix_p1         (pc_idix),
        .rs_idix_p1         (rs_idix),
        .rt_idix_p1         (rt_idix),
        .dest_idix_p1       (dest_idix),
        .dest_wr_idix_p1    (dest_wr_idix)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        inst_valid = 1'b0;
        inst       = '0;
        pc         = '0;
        rs_idx     = '0;
        rt_idx     = '0;
        rs_used    = 1'b0;
        rt_used    = 1'b0;
        dest_idx   = '0;
        dest_wr    = 1'b0;
        wb_valid   = '0;
        wb_index   = '0;
        wb_data    = '0;
        flush      = 1'b0;
        ready_ixid = 1'b1;
    endtask

    task automatic offer(input logic [15:0] i_inst, input logic [15:0] i_pc,
                         input logic [2:0] i_rs, input logic i_rsu,
                         input logic [2:0] i_rt, input logic i_rtu,
                         input logic [2:0] i_dest, input logic i_dwr);
        inst_valid = 1'b1;
        inst       = i_inst;
        pc         = i_pc;
        rs_idx     = i_rs;
        rs_used    = i_rsu;
        rt_idx     = i_rt;
        rt_used    = i_rtu;
        dest_idx   = i_dest;
        dest_wr    = i_dwr;
    endtask

    task automatic wb(input int p, input logic [2:0] idx, input logic [15:0] dat);
        wb_valid[p]                   = 1'b1;
        wb_index[p*IDX_W +: IDX_W]    = idx;
        wb_data[p*DATA_W +: DATA_W]   = dat;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        // Reset state, before and across a clock edge.
        #2;
        check_val("rst_valid", valid_idix, 0);
        check_val("rst_ready", id_ready, 0);
        check_val("rst_inst", inst_idix, 0);
        check_val("rst_rs", rs_idix, 0);
        @(posedge clk);
        #1;
        check_val("rst_valid_edge", valid_idix, 0);
        #1;
        rst = 1'b1;
        #1;
        check_val("rdy_after_rst", id_ready, 1);
        tick();

        // Write R3 then read it from the register file.
        idle(); wb(0, 3'd3, 16'h1234); tick();
        idle(); offer(16'h0103, 16'h0010, 3'd3, 1, 3'd0, 0, 3'd0, 0);
        settle(); check_val("rd_rdy", id_ready, 1);
        tick();
        check_val("rd_valid", valid_idix, 1);
        check_val("rd_rs", rs_idix, 16'h1234);
        check_val("rd_inst", inst_idix, 16'h0103);
        check_val("rd_pc", pc_idix, 16'h0010);
        check_val("rd_dwr", dest_wr_idix, 0);

        // Same-cycle bypass on port 1, then two ports on one index.
        idle(); wb(1, 3'd5, 16'hBEEF); offer(16'h0205, 16'h0012, 3'd0, 0, 3'd5, 1, 3'd0, 0);
        settle(); check_val("byp_rdy", id_ready, 1);
        tick();
        check_val("byp_rt", rt_idix, 16'hBEEF);
        check_val("byp_valid", valid_idix, 1);
        idle(); wb(0, 3'd2, 16'h1111); wb(1, 3'd2, 16'h2222);
        offer(16'h0302, 16'h0014, 3'd2, 1, 3'd5, 1, 3'd0, 0);
        tick();
        check_val("prio_byp_rs", rs_idix, 16'h2222);
        check_val("rf_r5", rt_idix, 16'hBEEF);
        idle(); offer(16'h0402, 16'h0016, 3'd3, 1, 3'd2, 1, 3'd0, 0);
        tick();
        check_val("rf_r3", rs_idix, 16'h1234);
        check_val("prio_rf_r2", rt_idix, 16'h2222);

        // RAW interlock on R4 released by a write-back in the issue cycle.
        idle(); offer(16'h0504, 16'h0020, 3'd0, 0, 3'd0, 0, 3'd4, 1);
        settle(); check_val("raw_prod_rdy", id_ready, 1);
        tick();
        check_val("raw_prod_dest", dest_idix, 4);
        check_val("raw_prod_dwr", dest_wr_idix, 1);
        for (int i = 0; i < 2; i++) begin
            idle(); offer(16'h0604, 16'h0022, 3'd4, 1, 3'd0, 0, 3'd0, 0);
            settle(); check_val("raw_stall", id_ready, 0);
            tick();
        end
        check_val("raw_drained", valid_idix, 0);
        idle(); offer(16'h0604, 16'h0022, 3'd4, 1, 3'd0, 0, 3'd0, 0); wb(0, 3'd4, 16'h00AA);
        settle(); check_val("raw_release", id_ready, 1);
        tick();
        check_val("raw_rs", rs_idix, 16'h00AA);
        check_val("raw_valid", valid_idix, 1);
        check_val("raw_inst", inst_idix, 16'h0604);
        idle(); offer(16'h0704, 16'h0024, 3'd4, 1, 3'd4, 1, 3'd0, 0);
        settle(); check_val("raw_cnt_zero", id_ready, 1);
        tick();
        check_val("raw_rf_rs", rs_idix, 16'h00AA);
        check_val("raw_rf_rt", rt_idix, 16'h00AA);

        // Counter saturation on R1.
        for (int i = 0; i < 3; i++) begin
            idle(); offer(16'h0800 + 16'(i), 16'h0030, 3'd0, 0, 3'd0, 0, 3'd1, 1);
            settle(); check_val("sat_fill_rdy", id_ready, 1);
            tick();
        end
        idle(); offer(16'h0810, 16'h0040, 3'd0, 0, 3'd0, 0, 3'd1, 1);
        settle(); check_val("sat_full", id_ready, 0);
        tick();
        idle(); offer(16'h0810, 16'h0040, 3'd0, 0, 3'd0, 0, 3'd1, 1); wb(1, 3'd1, 16'h0111);
        settle(); check_val("sat_release", id_ready, 1);
        tick();
        check_val("sat_inst", inst_idix, 16'h0810);
        check_val("sat_valid", valid_idix, 1);
        // Count is back at 3; two landings leave 1 outstanding.
        idle(); wb(0, 3'd1, 16'h0100); tick();
        idle(); wb(0, 3'd1, 16'h0101); tick();
        idle(); offer(16'h0901, 16'h0044, 3'd1, 1, 3'd0, 0, 3'd0, 0);
        settle(); check_val("sat_one_left", id_ready, 0);
        tick();
        idle(); offer(16'h0901, 16'h0044, 3'd1, 1, 3'd0, 0, 3'd0, 0); wb(0, 3'd1, 16'h0102);
        settle(); check_val("sat_last_rdy", id_ready, 1);
        tick();
        check_val("sat_last_rs", rs_idix, 16'h0102);

        // Backpressure holds the ID/IX register.
        idle(); offer(16'hAAAA, 16'h0100, 3'd3, 1, 3'd0, 0, 3'd0, 0);
        tick();
        check_val("bp_load", inst_idix, 16'hAAAA);
        for (int i = 0; i < 3; i++) begin
            idle(); ready_ixid = 1'b0; offer(16'hBBBB, 16'h0102, 3'd5, 1, 3'd0, 0, 3'd0, 0);
            settle(); check_val("bp_rdy", id_ready, 0);
            tick();
            check_val("bp_inst", inst_idix, 16'hAAAA);
            check_val("bp_pc", pc_idix, 16'h0100);
            check_val("bp_rs", rs_idix, 16'h1234);
            check_val("bp_valid", valid_idix, 1);
        end
        idle(); offer(16'hBBBB, 16'h0102, 3'd5, 1, 3'd0, 0, 3'd0, 0);
        settle(); check_val("bp_resume_rdy", id_ready, 1);
        tick();
        check_val("bp_xfer1_inst", inst_idix, 16'hBBBB);
        check_val("bp_xfer1_rs", rs_idix, 16'hBEEF);
        idle(); offer(16'hCCCC, 16'h0104, 3'd2, 1, 3'd0, 0, 3'd0, 0);
        settle(); check_val("bp_xfer2_rdy", id_ready, 1);
        tick();
        check_val("bp_xfer2_inst", inst_idix, 16'hCCCC);
        check_val("bp_xfer2_rs", rs_idix, 16'h2222);
        check_val("bp_xfer2_valid", valid_idix, 1);
        idle(); tick();
        check_val("drain_valid", valid_idix, 0);
        check_val("drain_hold", inst_idix, 16'hCCCC);

        // Flush during a stall on R6; write-back in the flush cycle survives.
        idle(); offer(16'h0D06, 16'h0200, 3'd0, 0, 3'd0, 0, 3'd6, 1);
        tick();
        check_val("fl_prod_valid", valid_idix, 1);
        check_val("fl_prod_dest", dest_idix, 6);
        idle(); ready_ixid = 1'b0; offer(16'h0E06, 16'h0202, 3'd6, 1, 3'd0, 0, 3'd0, 0);
        settle(); check_val("fl_pre_stall", id_ready, 0);
        tick();
        idle(); ready_ixid = 1'b0; flush = 1'b1; wb(0, 3'd7, 16'h7777);
        offer(16'h0E06, 16'h0202, 3'd6, 1, 3'd0, 0, 3'd0, 0);
        settle(); check_val("fl_rdy", id_ready, 0);
        tick();
        check_val("fl_valid", valid_idix, 0);
        check_val("fl_no_issue", inst_idix, 16'h0D06);
        idle(); offer(16'h0F06, 16'h0204, 3'd6, 1, 3'd7, 1, 3'd0, 0);
        settle(); check_val("fl_cnt_clr", id_ready, 1);
        tick();
        check_val("fl_rs", rs_idix, 16'h0000);
        check_val("fl_wb_kept", rt_idix, 16'h7777);
        check_val("fl_re_valid", valid_idix, 1);

        // Asynchronous reset mid-cycle, then issue on the first edge after release.
        idle(); ready_ixid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_valid", valid_idix, 0);
        check_val("arst_inst", inst_idix, 0);
        check_val("arst_rt", rt_idix, 0);
        check_val("arst_ready", id_ready, 0);
        #2;
        rst = 1'b1;
        idle(); offer(16'h1003, 16'h0300, 3'd3, 1, 3'd7, 1, 3'd0, 0);
        settle(); check_val("post_rst_rdy", id_ready, 1);
        tick();
        check_val("post_rst_valid", valid_idix, 1);
        check_val("post_rst_inst", inst_idix, 16'h1003);
        check_val("post_rst_rf3", rs_idix, 0);
        check_val("post_rst_rf7", rt_idix, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
